// File: rtl/pwd_lock_ctrl_if.sv
// Bus bundle for pwd_lock_ctrl: operator command strobes in, status out.
// master = operator side (drives commands), slave = controller side.
interface pwd_lock_ctrl_if #(
    parameter int CODE_W = 8
);
    // Handshake: start, code_vld, check, exit and prog are single-cycle strobes
    // sampled on the rising clock edge. There is no ready/backpressure; in any
    // cycle the controller either acts on a strobe or ignores it, depending on
    // its state. code_in is only looked at in a cycle where code_vld is high.
    logic              start;
    logic [CODE_W-1:0] code_in;
    logic              code_vld;
    logic              check;
    logic              exit;
    logic              prog;
    logic [2:0]        state;
    logic              unlocked;
    logic              err;
    logic [2:0]        fail_cnt;
    logic [3:0]        entry_idx;
    logic [12:0]       lock_rem;

    modport master (
        output start, code_in, code_vld, check, exit, prog,
        input  state, unlocked, err, fail_cnt, entry_idx, lock_rem
    );

    modport slave (
        input  start, code_in, code_vld, check, exit, prog,
        output state, unlocked, err, fail_cnt, entry_idx, lock_rem
    );
endinterface

// File: rtl/pwd_lock_ctrl.sv
// Password-lock controller: code entry and check, failure counting, timed
// lockout with a seconds countdown, and password reprogramming while open.
// Optional macro LOCKOUT_ESCALATE_EN doubles the lockout duration on each
// consecutive lockout (1x, 2x, 4x, 8x) until a successful unlock.
module pwd_lock_ctrl #(
    parameter int CODE_W    = 8,
    parameter int CODE_LEN  = 3,
    parameter int MAX_TRIES = 3,
    parameter int LOCK_SECS = 60,
    parameter int TICK_DIV  = 100000000,
    parameter logic [CODE_LEN*CODE_W-1:0] INIT_CODE = '0
) (
    input logic clk,
    input logic rst_n,
    pwd_lock_ctrl_if.slave bus
);
    localparam int                PRE_W    = $clog2(TICK_DIV);
    localparam int                IDX_W    = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam logic [3:0]        LEN4     = 4'(CODE_LEN);
    localparam logic [2:0]        MAX3     = 3'(MAX_TRIES);
    localparam logic [12:0]       BASE     = 13'(LOCK_SECS);
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOCKED  = 3'd1,
        S_ERROR   = 3'd2,
        S_LOCKOUT = 3'd3,
        S_OPEN    = 3'd4,
        S_PROG    = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CODE_W-1:0]  pwd_q    [CODE_LEN];
    logic [CODE_W-1:0]  pwd_d    [CODE_LEN];
    logic [CODE_W-1:0]  shadow_q [CODE_LEN];
    logic [CODE_W-1:0]  shadow_d [CODE_LEN];
    logic [PRE_W-1:0]   presc_q, presc_d;
    logic               bad_q, bad_d;
    logic               err_q, err_d;
    logic [2:0]         fail_q, fail_d;
    logic [2:0]         fail_inc;
    logic [3:0]         idx_q, idx_d;
    logic [IDX_W-1:0]   widx;
    logic [12:0]        rem_q, rem_d;
    logic [12:0]        duration;

`ifdef LOCKOUT_ESCALATE_EN
    logic [1:0]         level_q, level_d;
    assign duration = BASE << level_q;
`else
    assign duration = BASE;
`endif

    assign widx     = idx_q[IDX_W-1:0];
    assign fail_inc = fail_q + 3'd1;

    // State and datapath registers; every register reloads its reset value on rst_n low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            for (int i = 0; i < CODE_LEN; i++) begin
                pwd_q[i]    <= INIT_CODE[i*CODE_W +: CODE_W];
                shadow_q[i] <= '0;
            end
            presc_q <= '0;
            bad_q   <= 1'b0;
            err_q   <= 1'b0;
            fail_q  <= 3'd0;
            idx_q   <= 4'd0;
            rem_q   <= 13'd0;
`ifdef LOCKOUT_ESCALATE_EN
            level_q <= 2'd0;
`endif
        end else begin
            state_q  <= state_d;
            pwd_q    <= pwd_d;
            shadow_q <= shadow_d;
            presc_q  <= presc_d;
            bad_q    <= bad_d;
            err_q    <= err_d;
            fail_q   <= fail_d;
            idx_q    <= idx_d;
            rem_q    <= rem_d;
`ifdef LOCKOUT_ESCALATE_EN
            level_q  <= level_d;
`endif
        end
    end

    // Next-state and next-value logic; check always has priority over code_vld.
    always_comb begin
        state_d  = state_q;
        pwd_d    = pwd_q;
        shadow_d = shadow_q;
        presc_d  = presc_q;
        bad_d    = bad_q;
        err_d    = 1'b0;
        fail_d   = fail_q;
        idx_d    = idx_q;
        rem_d    = rem_q;
`ifdef LOCKOUT_ESCALATE_EN
        level_d  = level_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_LOCKED;
            end
            S_LOCKED: begin
                if (bus.check) begin
                    idx_d = 4'd0;
                    bad_d = 1'b0;
                    if (idx_q == LEN4 && !bad_q) begin
                        state_d = S_OPEN;
                        fail_d  = 3'd0;
`ifdef LOCKOUT_ESCALATE_EN
                        level_d = 2'd0;
`endif
                    end else begin
                        err_d = 1'b1;
                        if (fail_inc == MAX3) begin
                            state_d = S_LOCKOUT;
                            rem_d   = duration;
                            presc_d = '0;
                            fail_d  = 3'd0;
`ifdef LOCKOUT_ESCALATE_EN
                            level_d = (level_q == 2'd3) ? 2'd3 : level_q + 2'd1;
`endif
                        end else begin
                            state_d = S_ERROR;
                            fail_d  = fail_inc;
                        end
                    end
                end else if (bus.code_vld) begin
                    // A word beyond the password length spoils the entry.
                    if (idx_q == LEN4) begin
                        bad_d = 1'b1;
                    end else begin
                        if (bus.code_in != pwd_q[widx]) bad_d = 1'b1;
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_ERROR: begin
                state_d = S_LOCKED;
            end
            S_LOCKOUT: begin
                if (presc_q == PRE_LAST) begin
                    presc_d = '0;
                    if (rem_q <= 13'd1) begin
                        rem_d   = 13'd0;
                        state_d = S_LOCKED;
                    end else begin
                        rem_d = rem_q - 13'd1;
                    end
                end else begin
                    presc_d = presc_q + PRE_W'(1);
                end
            end
            S_OPEN: begin
                if (bus.exit) begin
                    state_d = S_LOCKED;
                    idx_d   = 4'd0;
                    bad_d   = 1'b0;
                end else if (bus.prog) begin
                    state_d = S_PROG;
                    idx_d   = 4'd0;
                end
            end
            S_PROG: begin
                if (bus.exit) begin
                    state_d = S_OPEN;
                    idx_d   = 4'd0;
                end else if (bus.code_vld) begin
                    shadow_d[widx] = bus.code_in;
                    idx_d          = idx_q + 4'd1;
                    // Last word written: commit the whole shadow at once.
                    if (idx_q == LEN4 - 4'd1) begin
                        pwd_d   = shadow_d;
                        state_d = S_OPEN;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.state     = state_q;
    assign bus.unlocked  = (state_q == S_OPEN) || (state_q == S_PROG);
    assign bus.err       = err_q;
    assign bus.fail_cnt  = fail_q;
    assign bus.entry_idx = idx_q;
    assign bus.lock_rem  = rem_q;
endmodule

// File: tb/tb_pwd_lock_ctrl.sv
// Bench for pwd_lock_ctrl: directed scenarios followed by random sessions.
// A reference model predicts every change of {state, err, fail_cnt, lock_rem}
// and its spacing in cycles; a monitor pops and compares on each change.
module tb_pwd_lock_ctrl;
    localparam int CODE_W    = 8;
    localparam int CODE_LEN  = 3;
    localparam int MAX_TRIES = 3;
    localparam int LOCK_SECS = 3;
    localparam int TICK_DIV  = 4;
    localparam logic [23:0] INIT_CODE = 24'h030201;

    typedef struct {
        logic [2:0]  st;
        logic        er;
        logic [2:0]  fc;
        logic [12:0] rem;
        int          delta;   // cycles since previous event, 0 = not checked
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    ev_t  exp_q[$];

    // Reference model state
    int          mstate;
    int          mfc;
    int          mlevel;
    logic [7:0]  mpwd[CODE_LEN];
    logic [7:0]  mshadow[CODE_LEN];
    int          pidx;
    logic [7:0]  entered[$];

    pwd_lock_ctrl_if #(.CODE_W(CODE_W)) bus ();

    pwd_lock_ctrl #(
        .CODE_W(CODE_W), .CODE_LEN(CODE_LEN), .MAX_TRIES(MAX_TRIES),
        .LOCK_SECS(LOCK_SECS), .TICK_DIV(TICK_DIV), .INIT_CODE(INIT_CODE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    task automatic push(input int st, input int er, input int fc, input int rem, input int delta);
        ev_t e;
        e.st = 3'(st); e.er = 1'(er); e.fc = 3'(fc); e.rem = 13'(rem); e.delta = delta;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        logic [23:0] init_v;
        init_v = INIT_CODE;
        for (int i = 0; i < CODE_LEN; i++) mpwd[i] = init_v[i*8 +: 8];
        mstate = 0; mfc = 0; mlevel = 0; pidx = 0;
        entered.delete();
    endtask

    task automatic clear_inputs();
        bus.start = 0; bus.code_vld = 0; bus.check = 0; bus.exit = 0; bus.prog = 0;
    endtask

    // One-cycle strobe driver
    task automatic drive(input logic s, input logic cv, input logic ck, input logic ex,
                         input logic pg, input logic [7:0] code);
        @(posedge clk); #1;
        bus.start = s; bus.code_vld = cv; bus.check = ck; bus.exit = ex; bus.prog = pg;
        bus.code_in = code;
        @(posedge clk); #1;
        clear_inputs();
        bus.code_in = 8'($urandom_range(0, 255));
    endtask

    task automatic do_start();
        if (mstate == 0) begin
            push(1, 0, mfc, 0, 0);
            mstate = 1;
        end
        drive(1, 0, 0, 0, 0, 8'h00);
    endtask

    task automatic enter_word(input logic [7:0] w);
        int e;
        entered.push_back(w);
        drive(0, 1, 0, 0, 0, w);
        e = (entered.size() > CODE_LEN) ? CODE_LEN : entered.size();
        chk("entry_idx", 32'(bus.entry_idx), 32'(e));
    endtask

    // Check the entry; on lockout, bash ignored inputs until it expires,
    // or apply reset after rst_at stray cycles when rst_at >= 0.
    task automatic do_check(input bit with_code, input int rst_at);
        bit pass;
        int dur, prev, t;
        pass = (entered.size() == CODE_LEN);
        if (pass) for (int i = 0; i < CODE_LEN; i++) if (entered[i] !== mpwd[i]) pass = 0;
        entered.delete();
        dur = 0;
        if (pass) begin
            push(4, 0, 0, 0, 0);
            mfc = 0; mlevel = 0; mstate = 4;
        end else begin
            mfc++;
            if (mfc == MAX_TRIES) begin
`ifdef LOCKOUT_ESCALATE_EN
                dur = LOCK_SECS << mlevel;
                if (mlevel < 3) mlevel++;
`else
                dur = LOCK_SECS;
`endif
                mfc = 0;
                push(3, 1, 0, dur, 0);
                push(3, 0, 0, dur, 1);
                prev = 1;
                for (int s = 1; s <= dur; s++) begin
                    t = s * TICK_DIV;
                    if (s < dur) push(3, 0, 0, dur - s, t - prev);
                    else         push(1, 0, 0, 0, t - prev);
                    prev = t;
                end
            end else begin
                push(2, 1, mfc, 0, 0);
                push(1, 0, mfc, 0, 1);
            end
            mstate = 1;
        end
        drive(0, with_code, 1, 0, 0, 8'($urandom_range(0, 255)));
        chk("entry_idx_after_check", 32'(bus.entry_idx), 32'd0);
        if (dur > 0) begin
            for (int i = 0; i < dur * TICK_DIV - 2; i++) begin
                @(posedge clk); #1;
                if (i == rst_at) begin
                    exp_q.delete();
                    clear_inputs();
                    model_reset();
                    push(0, 0, 0, 0, 0);
                    rst_n = 0;
                    @(posedge clk); #1;
                    @(posedge clk); #1;
                    rst_n = 1;
                    chk("rst_state", 32'(bus.state), 32'd0);
                    chk("rst_lock_rem", 32'(bus.lock_rem), 32'd0);
                    chk("rst_entry_idx", 32'(bus.entry_idx), 32'd0);
                    return;
                end
                bus.start = 1'($urandom); bus.code_vld = 1'($urandom);
                bus.check = 1'($urandom); bus.exit = 1'($urandom); bus.prog = 1'($urandom);
                bus.code_in = 8'($urandom_range(0, 255));
            end
            @(posedge clk); #1;
            clear_inputs();
            @(posedge clk); #1;
        end
    endtask

    task automatic do_exit(input bit with_prog);
        if (mstate == 4) begin push(1, 0, 0, 0, 0); mstate = 1; entered.delete(); end
        else if (mstate == 5) begin push(4, 0, 0, 0, 0); mstate = 4; end
        drive(0, 0, 0, 1, with_prog, 8'h00);
    endtask

    task automatic do_prog();
        push(5, 0, 0, 0, 0);
        mstate = 5; pidx = 0;
        drive(0, 0, 0, 0, 1, 8'h00);
    endtask

    task automatic prog_word(input logic [7:0] w);
        mshadow[pidx] = w;
        pidx++;
        if (pidx == CODE_LEN) begin
            for (int i = 0; i < CODE_LEN; i++) mpwd[i] = mshadow[i];
            push(4, 0, 0, 0, 0);
            mstate = 4;
        end
        drive(0, 1, 0, 0, 0, w);
    endtask

    task automatic enter_seq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int n);
        if (n > 0) enter_word(a);
        if (n > 1) enter_word(b);
        if (n > 2) enter_word(c);
    endtask

    // Monitor: compare each change of the observed outputs against the next expectation
    initial begin : monitor
        logic [19:0] prev, cur;
        int cyc, last_cyc, n;
        ev_t e;
        wait (mon_en);
        @(negedge clk);
        prev = {bus.state, bus.err, bus.fail_cnt, bus.lock_rem};
        cyc = 0; last_cyc = 0; n = 0;
        forever begin
            @(negedge clk);
            cyc++;
            cur = {bus.state, bus.err, bus.fail_cnt, bus.lock_rem};
            if (cur !== prev) begin
                n++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event #%0d st=%0d err=%0d fc=%0d rem=%0d",
                             n, bus.state, bus.err, bus.fail_cnt, bus.lock_rem);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== {e.st, e.er, e.fc, e.rem} ||
                        bus.unlocked !== (e.st == 3'd4 || e.st == 3'd5) ||
                        (e.delta != 0 && cyc - last_cyc != e.delta)) begin
                        errors++;
                        $display("FAIL event #%0d got st=%0d err=%0d fc=%0d rem=%0d unl=%0d gap=%0d exp st=%0d err=%0d fc=%0d rem=%0d gap=%0d",
                                 n, bus.state, bus.err, bus.fail_cnt, bus.lock_rem, bus.unlocked,
                                 cyc - last_cyc, e.st, e.er, e.fc, e.rem, e.delta);
                    end
                end
                last_cyc = cyc;
                prev = cur;
            end
        end
    end

    // Stimulus
    initial begin : stim
        int r, n;
        logic [7:0] w;
        rst_n = 0;
        clear_inputs();
        bus.code_in = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        chk("reset_state", 32'(bus.state), 32'd0);
        chk("reset_unlocked", 32'(bus.unlocked), 32'd0);
        chk("reset_err", 32'(bus.err), 32'd0);
        chk("reset_fail_cnt", 32'(bus.fail_cnt), 32'd0);
        chk("reset_entry_idx", 32'(bus.entry_idx), 32'd0);
        chk("reset_lock_rem", 32'(bus.lock_rem), 32'd0);
        mon_en = 1;
        @(posedge clk); #1;

        // Correct unlock
        do_start();
        enter_seq(8'h01, 8'h02, 8'h03, 3);
        do_check(0, -1);
        chk("open_unlocked", 32'(bus.unlocked), 32'd1);
        // Wrong word, then short entry, then lockout
        do_exit(0);
        enter_seq(8'h01, 8'h05, 8'h03, 3);
        do_check(0, -1);
        enter_seq(8'h01, 8'h02, 8'h00, 2);
        do_check(0, -1);
        chk("fail_cnt_two", 32'(bus.fail_cnt), 32'd2);
        do_check(0, -1);
        // Reprogramming
        enter_seq(8'h01, 8'h02, 8'h03, 3);
        do_check(0, -1);
        do_prog();
        prog_word(8'hAA); prog_word(8'hBB); prog_word(8'hCC);
        do_exit(0);
        enter_seq(8'h01, 8'h02, 8'h03, 3);
        do_check(0, -1);
        enter_seq(8'hAA, 8'hBB, 8'hCC, 3);
        do_check(0, -1);
        do_prog();
        prog_word(8'h11);
        do_exit(0);
        do_exit(0);
        enter_seq(8'hAA, 8'hBB, 8'hCC, 3);
        do_check(0, -1);
        // check with a simultaneous code word, then reset during lockout
        do_exit(0);
        enter_seq(8'hAA, 8'hBB, 8'hCC, 3);
        do_check(1, -1);
        do_exit(0);
        do_check(0, -1);
        do_check(0, -1);
        do_check(0, 5);
        do_start();
        enter_seq(8'h01, 8'h02, 8'h03, 3);
        do_check(0, -1);
        // Consecutive lockouts, unlock, another lockout
        do_exit(0);
        repeat (6) do_check(0, -1);
        enter_seq(8'h01, 8'h02, 8'h03, 3);
        do_check(0, -1);
        do_exit(0);
        repeat (3) do_check(0, -1);

        // Random sessions
        for (int it = 0; it < 60; it++) begin
            case (mstate)
                0: do_start();
                1: begin
                    n = $urandom_range(0, 4);
                    for (int i = 0; i < n; i++) begin
                        w = ($urandom_range(0, 3) != 0 && i < CODE_LEN) ? mpwd[i] : 8'($urandom_range(0, 255));
                        enter_word(w);
                    end
                    do_check($urandom_range(0, 3) == 0, -1);
                end
                4: begin
                    r = $urandom_range(0, 3);
                    if (r == 0) do_exit(0);
                    else if (r == 1) do_exit(1);
                    else if (r == 2) begin
                        do_prog();
                        for (int i = 0; i < CODE_LEN; i++) prog_word(8'($urandom_range(0, 255)));
                    end else begin
                        do_prog();
                        n = $urandom_range(0, CODE_LEN - 1);
                        for (int i = 0; i < n; i++) prog_word(8'($urandom_range(0, 255)));
                        do_exit(0);
                    end
                end
                default: do_start();
            endcase
        end

        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        chk("pending_events", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
